dma_reg_file: RTL and testbench

- CPU-side programming block of the 8237A-style DMA controller, and the writer/driver of the shared DMA register interface (address, word count, base, mode, command, request, mask, temp and status registers).
- Decodes CPU IOR/IOW cycles on A[3:0] and runs the byte-pointer flip-flop for 16-bit registers.
- Returns register contents on CPU reads.
- Takes per-transfer address/count updates and terminal-count events from the transfer FSM.

---
 rtl/dma_pkg.sv | 36 +++
 rtl/dma_reg_file_if.sv | 22 ++
 rtl/dma_chan_regs.sv | 93 +++++++++
 rtl/dma_reg_file.sv | 171 +++++++++++++++++
 tb/tb_dma_reg_file.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared definitions for the 8237A-style DMA register file.
// Contents:
//   - CPU register offsets on A[3:0] (write and read maps)
//   - MODE_AUTOINIT : autoinit bit position in the 8-bit mode byte
//   - chan_t        : channel number type
//   - modeAutoinit(): extracts the autoinit bit from a stored mode field
// -----------------------------------------------------------------------------
package dma_pkg;

  // Write map offsets above the channel address/word block (0x0-0x7)
  localparam logic [3:0] REG_CMD     = 4'h8;
  localparam logic [3:0] REG_REQ     = 4'h9;
  localparam logic [3:0] REG_SGLMASK = 4'hA;
  localparam logic [3:0] REG_MODE    = 4'hB;
  localparam logic [3:0] REG_CLRFF   = 4'hC;
  localparam logic [3:0] REG_MCLR    = 4'hD;
  localparam logic [3:0] REG_CLRMASK = 4'hE;
  localparam logic [3:0] REG_ALLMASK = 4'hF;

  // Read map offsets
  localparam logic [3:0] REG_STATUS  = 4'h8;
  localparam logic [3:0] REG_TEMP    = 4'hD;

  // Autoinit bit in [7:0] mode-byte numbering
  localparam int MODE_AUTOINIT = 4;

  typedef logic [1:0] chan_t;

  // Only mode bits [7:2] are stored, so the stored index is shifted down by 2
  function automatic logic modeAutoinit(input logic [5:0] mode);
    return mode[MODE_AUTOINIT-2];
  endfunction

endpackage

// File: rtl/dma_reg_file_if.sv
// -----------------------------------------------------------------------------
// dma_reg_file_if
// CPU programming bus of the DMA controller.
// Signals:
//   cs_n, ior_n, iow_n : chip select and read/write strobes, active low
//   a                  : register address
//   db_in              : CPU write data
//   db_out, db_oe      : read data and its drive enable
// Modports: master = CPU side, slave = register file.
// -----------------------------------------------------------------------------
interface dma_reg_file_if;
  logic       cs_n;
  logic       ior_n;
  logic       iow_n;
  logic [3:0] a;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;

  modport master (output cs_n, ior_n, iow_n, a, db_in, input db_out, db_oe);
  modport slave  (input cs_n, ior_n, iow_n, a, db_in, output db_out, db_oe);
endinterface

// File: rtl/dma_chan_regs.sv
// -----------------------------------------------------------------------------
// dma_chan_regs
// One channel's base/current address and word registers.
// Ports:
//   i_clk, i_rst_n           : clock, async active-low reset
//   i_clr                    : master clear (synchronous)
//   i_cpuWe, i_cpuWord       : CPU byte write strobe, selects word (1) or address (0)
//   i_cpuHi, i_cpuData       : byte select from the pointer flip-flop, write byte
//   i_updEn, i_updAddr/Word  : transfer FSM update of the current registers
//   i_reload                 : autoinit reload of current from base
//   o_curAddr/Word, o_baseAddr/Word : register contents
// -----------------------------------------------------------------------------
module dma_chan_regs #(
  parameter int AW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_cpuWe,
  input  logic          i_cpuWord,
  input  logic          i_cpuHi,
  input  logic [7:0]    i_cpuData,
  input  logic          i_updEn,
  input  logic [AW-1:0] i_updAddr,
  input  logic [AW-1:0] i_updWord,
  input  logic          i_reload,
  output logic [AW-1:0] o_curAddr,
  output logic [AW-1:0] o_curWord,
  output logic [AW-1:0] o_baseAddr,
  output logic [AW-1:0] o_baseWord
);

  logic [AW-1:0] r_curAddr, r_curWord, r_baseAddr, r_baseWord;
  logic [AW-1:0] w_curAddrWr, w_curWordWr, w_baseAddrWr, w_baseWordWr;

  // Merge the CPU byte into each register, keeping the other byte intact
  always_comb begin
    w_curAddrWr  = r_curAddr;
    w_curWordWr  = r_curWord;
    w_baseAddrWr = r_baseAddr;
    w_baseWordWr = r_baseWord;
    if (i_cpuHi) begin
      w_curAddrWr[15:8]  = i_cpuData;
      w_curWordWr[15:8]  = i_cpuData;
      w_baseAddrWr[15:8] = i_cpuData;
      w_baseWordWr[15:8] = i_cpuData;
    end else begin
      w_curAddrWr[7:0]   = i_cpuData;
      w_curWordWr[7:0]   = i_cpuData;
      w_baseAddrWr[7:0]  = i_cpuData;
      w_baseWordWr[7:0]  = i_cpuData;
    end
  end

  // Priority per register: master clear, CPU write, autoinit reload, FSM update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_curAddr  <= '0;
      r_curWord  <= '0;
      r_baseAddr <= '0;
      r_baseWord <= '0;
    end else if (i_clr) begin
      r_curAddr  <= '0;
      r_curWord  <= '0;
      r_baseAddr <= '0;
      r_baseWord <= '0;
    end else begin
      if (i_cpuWe && !i_cpuWord) begin
        r_baseAddr <= w_baseAddrWr;
        r_curAddr  <= w_curAddrWr;
      end else if (i_reload) begin
        r_curAddr  <= r_baseAddr;
      end else if (i_updEn) begin
        r_curAddr  <= i_updAddr;
      end

      if (i_cpuWe && i_cpuWord) begin
        r_baseWord <= w_baseWordWr;
        r_curWord  <= w_curWordWr;
      end else if (i_reload) begin
        r_curWord  <= r_baseWord;
      end else if (i_updEn) begin
        r_curWord  <= i_updWord;
      end
    end
  end

  assign o_curAddr  = r_curAddr;
  assign o_curWord  = r_curWord;
  assign o_baseAddr = r_baseAddr;
  assign o_baseWord = r_baseWord;

endmodule

// File: rtl/dma_reg_file.sv
// -----------------------------------------------------------------------------
// dma_reg_file
// CPU-side programming block of the DMA controller; owns all DMA registers.
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   cpu                     : CPU bus (dma_reg_file_if.slave)
//   i_dreq                  : synchronised channel requests (status [7:4])
//   i_updEn/Ch/Addr/Word    : transfer FSM current-register update
//   i_tcPulse               : terminal count on i_updCh
//   i_tempIn, i_tempLd      : temporary register load
//   o_curAddr .. o_baseWord : per-channel registers, channel 0 in the LSBs
//   o_mode                  : mode bits [7:2] per channel
//   o_command, o_request, o_mask, o_temp, o_status : global registers
// -----------------------------------------------------------------------------
module dma_reg_file
  import dma_pkg::*;
#(
  parameter int NCH = 4,
  parameter int AW  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dma_reg_file_if.slave     cpu,
  input  logic [3:0]        i_dreq,
  input  logic              i_updEn,
  input  chan_t             i_updCh,
  input  logic [AW-1:0]     i_updAddr,
  input  logic [AW-1:0]     i_updWord,
  input  logic              i_tcPulse,
  input  logic [7:0]        i_tempIn,
  input  logic              i_tempLd,
  output logic [NCH*AW-1:0] o_curAddr,
  output logic [NCH*AW-1:0] o_curWord,
  output logic [NCH*AW-1:0] o_baseAddr,
  output logic [NCH*AW-1:0] o_baseWord,
  output logic [NCH*6-1:0]  o_mode,
  output logic [7:0]        o_command,
  output logic [7:0]        o_request,
  output logic [7:0]        o_mask,
  output logic [7:0]        o_temp,
  output logic [7:0]        o_status
);

  logic          r_wrActive, r_rdActive, r_ff;
  logic [3:0]    r_wrAddr, r_rdAddr;
  logic [7:0]    r_wrData, r_command, r_temp;
  logic [3:0]    r_request, r_mask, r_tc;
  logic [5:0]    r_mode [NCH];

  logic [AW-1:0] w_curAddr [NCH];
  logic [AW-1:0] w_curWord [NCH];
  logic [AW-1:0] w_rdReg;
  logic [7:0]    w_status;
  logic          w_wrCommit, w_rdDone, w_mclr, w_chWr, w_chRd, w_statRd;

  // A strobe commits on its rising edge, and only if CS stayed low up to then
  assign w_wrCommit = r_wrActive && cpu.iow_n;
  assign w_rdDone   = r_rdActive && cpu.ior_n;
  assign w_mclr     = w_wrCommit && (r_wrAddr == REG_MCLR);
  assign w_chWr     = w_wrCommit && !r_wrAddr[3];
  assign w_chRd     = w_rdDone && !r_rdAddr[3];
  assign w_statRd   = w_rdDone && (r_rdAddr == REG_STATUS);
  assign w_status   = {i_dreq, r_tc};

  // Bus capture: address/data tracked every cycle the strobe is active
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrActive <= 1'b0;
      r_rdActive <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
      r_rdAddr   <= '0;
    end else begin
      r_wrActive <= !cpu.cs_n && !cpu.iow_n;
      r_rdActive <= !cpu.cs_n && !cpu.ior_n;
      if (!cpu.cs_n && !cpu.iow_n) begin
        r_wrAddr <= cpu.a;
        r_wrData <= cpu.db_in;
      end
      if (!cpu.cs_n && !cpu.ior_n) begin
        r_rdAddr <= cpu.a;
      end
    end
  end

  // Global registers; later assignments win, so CPU commits override TC
  // effects and a new TC flag survives a same-cycle status-read clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff      <= 1'b0;
      r_command <= '0;
      r_request <= '0;
      r_mask    <= 4'hF;
      r_tc      <= '0;
      r_temp    <= '0;
      for (int i = 0; i < NCH; i++) r_mode[i] <= '0;
    end else if (w_mclr) begin
      r_ff      <= 1'b0;
      r_command <= '0;
      r_request <= '0;
      r_mask    <= 4'hF;
      r_tc      <= '0;
      r_temp    <= '0;
      for (int i = 0; i < NCH; i++) r_mode[i] <= '0;
    end else begin
      if (i_tempLd) r_temp <= i_tempIn;
      if (w_statRd) r_tc <= '0;
      if (i_tcPulse) begin
        r_tc[i_updCh]      <= 1'b1;
        r_request[i_updCh] <= 1'b0;
        if (!modeAutoinit(r_mode[i_updCh])) r_mask[i_updCh] <= 1'b1;
      end
      if (w_wrCommit && (r_wrAddr == REG_CLRFF)) r_ff <= 1'b0;
      else r_ff <= r_ff ^ w_chWr ^ w_chRd;
      if (w_wrCommit) begin
        case (r_wrAddr)
          REG_CMD:     r_command <= r_wrData;
          REG_REQ:     r_request[r_wrData[1:0]] <= r_wrData[2];
          REG_SGLMASK: r_mask[r_wrData[1:0]] <= r_wrData[2];
          REG_MODE:    r_mode[r_wrData[1:0]] <= r_wrData[7:2];
          REG_CLRMASK: r_mask <= '0;
          REG_ALLMASK: r_mask <= r_wrData[3:0];
          default:     ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    dma_chan_regs #(.AW(AW)) u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (w_mclr),
      .i_cpuWe    (w_chWr && (r_wrAddr[2:1] == chan_t'(g))),
      .i_cpuWord  (r_wrAddr[0]),
      .i_cpuHi    (r_ff),
      .i_cpuData  (r_wrData),
      .i_updEn    (i_updEn && (i_updCh == chan_t'(g))),
      .i_updAddr  (i_updAddr),
      .i_updWord  (i_updWord),
      .i_reload   (i_tcPulse && (i_updCh == chan_t'(g)) && modeAutoinit(r_mode[g])),
      .o_curAddr  (w_curAddr[g]),
      .o_curWord  (w_curWord[g]),
      .o_baseAddr (o_baseAddr[g*AW +: AW]),
      .o_baseWord (o_baseWord[g*AW +: AW])
    );
    assign o_curAddr[g*AW +: AW] = w_curAddr[g];
    assign o_curWord[g*AW +: AW] = w_curWord[g];
    assign o_mode[g*6 +: 6]      = r_mode[g];
  end

  // Read data is combinational for the duration of the strobe
  always_comb begin
    cpu.db_out = '0;
    cpu.db_oe  = 1'b0;
    w_rdReg    = cpu.a[0] ? w_curWord[cpu.a[2:1]] : w_curAddr[cpu.a[2:1]];
    if (!cpu.cs_n && !cpu.ior_n) begin
      cpu.db_oe = 1'b1;
      if (!cpu.a[3]) cpu.db_out = r_ff ? w_rdReg[15:8] : w_rdReg[7:0];
      else if (cpu.a == REG_STATUS) cpu.db_out = w_status;
      else if (cpu.a == REG_TEMP) cpu.db_out = r_temp;
    end
  end

  assign o_command = r_command;
  assign o_request = {4'b0, r_request};
  assign o_mask    = {4'b0, r_mask};
  assign o_temp    = r_temp;
  assign o_status  = w_status;

endmodule

// File: tb/tb_dma_reg_file.sv
// -----------------------------------------------------------------------------
// tb_dma_reg_file
// Directed self-checking bench for dma_reg_file with hand-computed values.
// -----------------------------------------------------------------------------
module tb_dma_reg_file;
  import dma_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  dreq;
  logic        updEn;
  chan_t       updCh;
  logic [15:0] updAddr, updWord;
  logic        tcPulse;
  logic [7:0]  tempIn;
  logic        tempLd;
  logic [63:0] curAddr, curWord, baseAddr, baseWord;
  logic [23:0] mode;
  logic [7:0]  command, request, mask, temp, status;
  logic [7:0]  rdData;
  logic        rdOe;

  int nAsserts = 0;
  int nFails   = 0;

  dma_reg_file_if cpu ();

  dma_reg_file #(.NCH(4), .AW(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .cpu        (cpu),
    .i_dreq     (dreq),
    .i_updEn    (updEn),
    .i_updCh    (updCh),
    .i_updAddr  (updAddr),
    .i_updWord  (updWord),
    .i_tcPulse  (tcPulse),
    .i_tempIn   (tempIn),
    .i_tempLd   (tempLd),
    .o_curAddr  (curAddr),
    .o_curWord  (curWord),
    .o_baseAddr (baseAddr),
    .o_baseWord (baseWord),
    .o_mode     (mode),
    .o_command  (command),
    .o_request  (request),
    .o_mask     (mask),
    .o_temp     (temp),
    .o_status   (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full CPU write cycle; the commit lands on the edge after IOW_N rises
  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
    @(negedge clk);
    cpu.cs_n = 1'b0; cpu.iow_n = 1'b0; cpu.a = addr; cpu.db_in = data;
    @(negedge clk);
    cpu.iow_n = 1'b1;
    @(negedge clk);
    cpu.cs_n = 1'b1;
  endtask

  // Full CPU read cycle; data sampled while the strobe is low
  task automatic cpuRead(input logic [3:0] addr, output logic [7:0] data, output logic oe);
    @(negedge clk);
    cpu.cs_n = 1'b0; cpu.ior_n = 1'b0; cpu.a = addr;
    #1;
    data = cpu.db_out;
    oe   = cpu.db_oe;
    @(negedge clk);
    cpu.ior_n = 1'b1;
    @(negedge clk);
    cpu.cs_n = 1'b1;
  endtask

  // One-cycle FSM update, optionally with terminal count
  task automatic fsmPulse(input chan_t ch, input logic en, input logic tc,
                          input logic [15:0] addr, input logic [15:0] word);
    @(negedge clk);
    updCh = ch; updEn = en; tcPulse = tc; updAddr = addr; updWord = word;
    @(negedge clk);
    updEn = 1'b0; tcPulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu.cs_n = 1'b1; cpu.ior_n = 1'b1; cpu.iow_n = 1'b1; cpu.a = '0; cpu.db_in = '0;
    dreq = '0; updEn = 1'b0; updCh = '0; updAddr = '0; updWord = '0;
    tcPulse = 1'b0; tempIn = '0; tempLd = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_mask", mask, 64'h0F);
    checkOutput("rst_command", command, 64'h00);
    checkOutput("rst_curAddr", curAddr, 64'h0);
    checkOutput("rst_baseWord", baseWord, 64'h0);
    checkOutput("rst_status", status, 64'h00);
    checkOutput("rst_db_oe", cpu.db_oe, 64'h0);
    checkOutput("rst_db_out", cpu.db_out, 64'h0);
    rst_n = 1'b1;

    // Two-byte programming of channel 1 address
    applyStimulus(4'h2, 8'h34);
    applyStimulus(4'h2, 8'h12);
    checkOutput("ch1_baseAddr", baseAddr[31:16], 64'h1234);
    checkOutput("ch1_curAddr", curAddr[31:16], 64'h1234);
    cpuRead(4'h2, rdData, rdOe);
    checkOutput("rd_ch1_lo", rdData, 64'h34);
    checkOutput("rd_oe", rdOe, 64'h1);
    cpuRead(4'h2, rdData, rdOe);
    checkOutput("rd_ch1_hi", rdData, 64'h12);

    // Mask register writes
    applyStimulus(REG_ALLMASK, 8'h05);
    checkOutput("mask_all", mask, 64'h05);
    applyStimulus(REG_SGLMASK, 8'h06);
    checkOutput("mask_sgl_ch2", mask, 64'h05);
    applyStimulus(REG_SGLMASK, 8'h07);
    applyStimulus(REG_SGLMASK, 8'h05);
    checkOutput("mask_sgl_ch3_ch1", mask, 64'h0F);
    applyStimulus(REG_SGLMASK, 8'h01);
    checkOutput("mask_sgl_clr1", mask, 64'h0D);
    applyStimulus(REG_CLRMASK, 8'h00);
    checkOutput("mask_clr", mask, 64'h00);

    // Master clear with ff left at 1
    applyStimulus(REG_CMD, 8'h5A);
    checkOutput("command", command, 64'h5A);
    applyStimulus(4'h0, 8'h99);
    applyStimulus(REG_MCLR, 8'h00);
    checkOutput("mclr_mask", mask, 64'h0F);
    checkOutput("mclr_command", command, 64'h00);
    checkOutput("mclr_curAddr", curAddr, 64'h0);
    applyStimulus(4'h6, 8'hAB);
    checkOutput("mclr_ff", baseAddr[63:48], 64'h00AB);
    applyStimulus(REG_CLRFF, 8'h00);
    applyStimulus(4'h6, 8'hCD);
    checkOutput("clrff", baseAddr[63:48], 64'h00CD);
    applyStimulus(REG_CLRFF, 8'h00);

    // Channel 2 autoinit reload on TC
    applyStimulus(4'h5, 8'h10);
    applyStimulus(4'h5, 8'h00);
    checkOutput("ch2_baseWord", baseWord[47:32], 64'h0010);
    applyStimulus(REG_MODE, 8'h56);
    checkOutput("ch2_mode", mode[17:12], 64'h15);
    applyStimulus(REG_CLRMASK, 8'h00);
    dreq = 4'hA;
    fsmPulse(2'd2, 1'b1, 1'b0, 16'h0100, 16'h0005);
    checkOutput("ch2_upd_word", curWord[47:32], 64'h0005);
    checkOutput("ch2_upd_addr", curAddr[47:32], 64'h0100);
    fsmPulse(2'd2, 1'b1, 1'b1, 16'h0999, 16'hFFFF);
    checkOutput("ch2_reload_word", curWord[47:32], 64'h0010);
    checkOutput("ch2_reload_addr", curAddr[47:32], 64'h0000);
    checkOutput("ch2_tc_status", status, 64'hA4);
    checkOutput("ch2_tc_mask", mask, 64'h00);
    cpuRead(REG_STATUS, rdData, rdOe);
    checkOutput("rd_status", rdData, 64'hA4);
    checkOutput("status_cleared", status, 64'hA0);

    // TC on ch3 (no autoinit) then status read colliding with TC on ch1
    fsmPulse(2'd3, 1'b0, 1'b1, 16'h0, 16'h0);
    checkOutput("ch3_tc_status", status, 64'hA8);
    checkOutput("ch3_tc_mask", mask, 64'h08);
    @(negedge clk);
    cpu.cs_n = 1'b0; cpu.ior_n = 1'b0; cpu.a = REG_STATUS;
    #1 rdData = cpu.db_out;
    @(negedge clk);
    cpu.ior_n = 1'b1; tcPulse = 1'b1; updCh = 2'd1;
    @(negedge clk);
    cpu.cs_n = 1'b1; tcPulse = 1'b0;
    checkOutput("rd_status2", rdData, 64'hA8);
    checkOutput("tc_vs_clear", status, 64'hA2);
    checkOutput("ch1_tc_mask", mask, 64'h0A);

    // Channel 0 request cleared by TC, mask set
    applyStimulus(REG_MODE, 8'h48);
    checkOutput("ch0_mode", mode[5:0], 64'h12);
    applyStimulus(REG_REQ, 8'h04);
    applyStimulus(REG_REQ, 8'h07);
    checkOutput("request_set", request, 64'h09);
    fsmPulse(2'd0, 1'b1, 1'b1, 16'h1111, 16'h0000);
    checkOutput("ch0_tc_request", request, 64'h08);
    checkOutput("ch0_tc_mask", mask, 64'h0B);
    checkOutput("ch0_tc_status", status, 64'hA3);
    checkOutput("ch0_tc_upd", curAddr[15:0], 64'h1111);
    applyStimulus(REG_REQ, 8'h03);
    checkOutput("request_clr", request, 64'h00);

    // CPU commit to ch0 word colliding with FSM update of ch0
    @(negedge clk);
    cpu.cs_n = 1'b0; cpu.iow_n = 1'b0; cpu.a = 4'h1; cpu.db_in = 8'h5C;
    @(negedge clk);
    cpu.iow_n = 1'b1; updEn = 1'b1; updCh = 2'd0; updAddr = 16'h2222; updWord = 16'h3333;
    @(negedge clk);
    cpu.cs_n = 1'b1; updEn = 1'b0;
    checkOutput("coll_curWord", curWord[15:0], 64'h005C);
    checkOutput("coll_baseWord", baseWord[15:0], 64'h005C);
    checkOutput("coll_curAddr", curAddr[15:0], 64'h2222);

    // Interrupted strobe: CS rises first, nothing commits
    @(negedge clk);
    cpu.cs_n = 1'b0; cpu.iow_n = 1'b0; cpu.a = REG_CMD; cpu.db_in = 8'hFF;
    @(negedge clk);
    cpu.cs_n = 1'b1;
    @(negedge clk);
    cpu.iow_n = 1'b1;
    @(negedge clk);
    checkOutput("dropped_cmd", command, 64'h00);
    applyStimulus(4'h0, 8'h77);
    checkOutput("dropped_ff_base", baseAddr[15:0], 64'h7700);
    checkOutput("dropped_ff_cur", curAddr[15:0], 64'h7722);

    // Temporary register
    @(negedge clk);
    tempIn = 8'h3C; tempLd = 1'b1;
    @(negedge clk);
    tempLd = 1'b0;
    checkOutput("temp", temp, 64'h3C);
    cpuRead(REG_TEMP, rdData, rdOe);
    checkOutput("rd_temp", rdData, 64'h3C);
    cpuRead(4'hE, rdData, rdOe);
    checkOutput("rd_unmapped", rdData, 64'h00);
    checkOutput("idle_db_oe", cpu.db_oe, 64'h0);

    // Reset in the middle of a write
    @(negedge clk);
    cpu.cs_n = 1'b0; cpu.iow_n = 1'b0; cpu.a = REG_CMD; cpu.db_in = 8'h77;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mask", mask, 64'h0F);
    checkOutput("midrst_curAddr", curAddr, 64'h0);
    checkOutput("midrst_temp", temp, 64'h00);
    checkOutput("midrst_status", status, 64'hA0);
    @(negedge clk);
    cpu.iow_n = 1'b1; cpu.cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_commit", command, 64'h00);
    checkOutput("midrst_mode", mode, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
